// File: rtl/seg7_pkg.sv
// Shared constants, font and helpers for the multiplexed 7-segment controller.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   // One display-buffer slot: code, leading-zero blank flag and decimal point.
   typedef struct packed {
      logic [3:0] code;
      logic       blank;
      logic       dp;
   } digit_t;

   // Active-low {a,b,c,d,e,f,g} hex font.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side load/config bus plus the display pins of the 7-segment controller.
interface seg7_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4,
   parameter int DATA_W     = 10
);
   logic [DATA_W-1:0]     data_in;
   logic                  load;
   logic                  mode;
   logic                  blank_lz;
   logic [NUM_DIGITS-1:0] dp_in;
   logic [6:0]            seg;
   logic                  dp;
   logic [NUM_DIGITS-1:0] an;
   logic                  busy;

   modport master (
      output data_in, load, mode, blank_lz, dp_in,
      input  seg, dp, an, busy
   );

   modport slave (
      input  data_in, load, mode, blank_lz, dp_in,
      output seg, dp, an, busy
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per cycle for DATA_W cycles.
// done pulses on the last shift with bcd_out carrying the final value; start is ignored while busy.
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int DATA_W     = 10,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [DATA_W-1:0]       bin_in,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    ovf
);
   localparam int              BW       = 4 * NUM_DIGITS;
   localparam int              CW       = $clog2(DATA_W + 1);
   localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
   localparam logic [63:0]     OVF_LIM  = pow10(NUM_DIGITS);
   localparam logic [0:0]      IDLE     = 1'b0;
   localparam logic [0:0]      SHIFT    = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] bin_q, bin_d;
   logic [BW-1:0]     bcd_q, bcd_d, bcd_adj;
   logic              ovf_q, ovf_d;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Digits above NUM_DIGITS are never kept: lower digits never depend on
   // them, and any value that would need them is flagged as overflow.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               bin_d   = bin_in;
               bcd_d   = '0;
               ovf_d   = (64'(bin_in) >= OVF_LIM);
            end
         end
         default: begin
            bcd_d = {bcd_adj[BW-2:0], bin_q[DATA_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy    = (state_q == SHIFT);
   assign bcd_out = bcd_d;
   assign ovf     = ovf_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment controller: hex or decimal rendering of a latched value.
// Hex loads reach the buffer in 1 cycle, decimal in DATA_W+1; loads are dropped while busy.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DATA_W      = 10,
   parameter int REFRESH_DIV = 50000
) (
   input  logic           clk,
   input  logic           rst_n,
   seg7_scan_ctrl_if.slave bus
);
   localparam int            BW    = 4 * NUM_DIGITS;
   localparam int            RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int            IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);

   logic [RW-1:0]                 ref_q, ref_d;
   logic [IW-1:0]                 idx_q, idx_d;
   digit_t [NUM_DIGITS-1:0]       buf_q, buf_d;
   logic                          dash_q, dash_d;
   logic                          pend_blz_q, pend_blz_d;
   logic [NUM_DIGITS-1:0]         pend_dp_q, pend_dp_d;
   logic [6:0]                    seg_q, seg_d;
   logic                          dpo_q, dpo_d;
   logic [NUM_DIGITS-1:0]         an_q, an_d;

   logic                          busy;
   logic                          load_acc;
   logic                          dec_start;
   logic                          bcd_done;
   logic                          bcd_ovf;
   logic [BW-1:0]                 bcd_val;

   logic                          wr_en;
   logic [BW-1:0]                 wr_codes;
   logic                          wr_blz;
   logic [NUM_DIGITS-1:0]         wr_dp;
   logic                          wr_dash;
   logic                          lead;
   digit_t                        cur;

   assign load_acc  = bus.load && !busy;
   assign dec_start = load_acc && bus.mode;

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (dec_start),
      .bin_in  (bus.data_in),
      .busy    (busy),
      .done    (bcd_done),
      .bcd_out (bcd_val),
      .ovf     (bcd_ovf)
   );

   // Source select for a buffer write; hex and conversion-done never coincide
   // because a load is only accepted while the converter is idle.
   always_comb begin
      wr_en     = 1'b0;
      wr_codes  = '0;
      wr_blz    = 1'b0;
      wr_dp     = '0;
      wr_dash   = 1'b0;
      pend_blz_d = pend_blz_q;
      pend_dp_d  = pend_dp_q;
      if (dec_start) begin
         pend_blz_d = bus.blank_lz;
         pend_dp_d  = bus.dp_in;
      end
      if (load_acc && !bus.mode) begin
         wr_en                = 1'b1;
         wr_codes[DATA_W-1:0] = bus.data_in;
         wr_blz               = bus.blank_lz;
         wr_dp                = bus.dp_in;
      end else if (bcd_done) begin
         wr_en    = 1'b1;
         wr_codes = bcd_val;
         wr_blz   = pend_blz_q;
         wr_dp    = pend_dp_q;
         wr_dash  = bcd_ovf;
      end
   end

   always_comb begin
      buf_d  = buf_q;
      dash_d = dash_q;
      lead   = wr_blz && !wr_dash;
      if (wr_en) begin
         dash_d = wr_dash;
         for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead           = lead && (wr_codes[4*i +: 4] == 4'd0) && (i != 0);
            buf_d[i].code  = wr_codes[4*i +: 4];
            buf_d[i].blank = lead;
            buf_d[i].dp    = wr_dp[i];
         end
      end
   end

   always_comb begin
      ref_d = ref_q + 1'b1;
      idx_d = idx_q;
      if (ref_q == RLAST) begin
         ref_d = '0;
         idx_d = (idx_q == ILAST) ? '0 : idx_q + 1'b1;
      end
   end

   always_comb begin
      cur = buf_q[idx_q];
      if (dash_q) begin
         seg_d = SEG_DASH;
      end else if (cur.blank) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = hex_to_seg(cur.code);
      end
      dpo_d = !(cur.dp && !cur.blank && !dash_q);
      an_d  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_d[i] = (IW'(i) != idx_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q      <= '0;
         idx_q      <= '0;
         buf_q      <= '0;
         dash_q     <= 1'b0;
         pend_blz_q <= 1'b0;
         pend_dp_q  <= '0;
         seg_q      <= SEG_BLANK;
         dpo_q      <= 1'b1;
         an_q       <= '1;
      end else begin
         ref_q      <= ref_d;
         idx_q      <= idx_d;
         buf_q      <= buf_d;
         dash_q     <= dash_d;
         pend_blz_q <= pend_blz_d;
         pend_dp_q  <= pend_dp_d;
         seg_q      <= seg_d;
         dpo_q      <= dpo_d;
         an_q       <= an_d;
      end
   end

   assign bus.seg  = seg_q;
   assign bus.dp   = dpo_q;
   assign bus.an   = an_q;
   assign bus.busy = busy;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: a 4-digit and a 3-digit controller share one randomized load stream.
module tb_seg7_scan_ctrl;
   localparam int DW = 10;
   localparam int RD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   typedef struct {
      int          apply;
      logic [27:0] s4;
      logic [3:0]  p4;
      logic [20:0] s3;
      logic [2:0]  p3;
   } img_t;

   img_t q[$];
   img_t cur;
   int   next_free = 0;
   int   bz_lo     = 1;
   int   bz_hi     = 0;

   logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   seg7_scan_ctrl_if #(.NUM_DIGITS(4), .DATA_W(DW)) bus4 ();
   seg7_scan_ctrl_if #(.NUM_DIGITS(3), .DATA_W(DW)) bus3 ();

   seg7_scan_ctrl #(.NUM_DIGITS(4), .DATA_W(DW), .REFRESH_DIV(RD)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4));
   seg7_scan_ctrl #(.NUM_DIGITS(3), .DATA_W(DW), .REFRESH_DIV(RD)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic longint p10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic longint p16(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 16;
      return p;
   endfunction

   // Expected pins for digit i of an nd-digit display showing value v.
   function automatic void exp_digit(input longint v, input bit dec, input bit blz, input bit dpb,
                                     input int i, input int nd,
                                     output logic [6:0] s, output logic p);
      int     d;
      longint lim;
      if (dec && v >= p10(nd)) begin
         s = 7'b1111110;
         p = 1'b1;
         return;
      end
      d   = dec ? int'((v / p10(i)) % 64'sd10) : int'((v >> (4 * i)) % 64'sd16);
      lim = dec ? p10(i) : p16(i);
      if (blz && i > 0 && v < lim) begin
         s = 7'b1111111;
         p = 1'b1;
      end else begin
         s = font[d];
         p = !dpb;
      end
   endfunction

   function automatic img_t mk_img(input longint v, input bit dec, input bit blz,
                                   input logic [3:0] dpi, input int apply);
      img_t       m;
      logic [6:0] s;
      logic       p;
      m.apply = apply;
      for (int i = 0; i < 4; i++) begin
         exp_digit(v, dec, blz, dpi[i], i, 4, s, p);
         m.s4[7*i +: 7] = s;
         m.p4[i]        = p;
      end
      for (int i = 0; i < 3; i++) begin
         exp_digit(v, dec, blz, dpi[i], i, 3, s, p);
         m.s3[7*i +: 7] = s;
         m.p3[i]        = p;
      end
      return m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle the pins must match the current expected image at
   // the digit the scan position implies from elapsed cycles.
   initial begin
      int         k, d4, d3;
      logic [3:0] an4e;
      logic [2:0] an3e;
      logic       busy_e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst4", 32'({bus4.an, bus4.seg, bus4.dp, bus4.busy}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
            chk("rst3", 32'({bus3.an, bus3.seg, bus3.dp, bus3.busy}), 32'({3'h7, 7'h7F, 1'b1, 1'b0}));
         end else if (cyc >= 1) begin
            k = cyc;
            while (q.size() > 0 && q[0].apply <= k - 1) cur = q.pop_front();
            d4     = ((k - 1) / RD) % 4;
            d3     = ((k - 1) / RD) % 3;
            an4e   = ~(4'd1 << d4);
            an3e   = ~(3'd1 << d3);
            busy_e = (k >= bz_lo) && (k <= bz_hi);
            chk("scan4", 32'({bus4.an, bus4.seg, bus4.dp}), 32'({an4e, cur.s4[7*d4 +: 7], cur.p4[d4]}));
            chk("scan3", 32'({bus3.an, bus3.seg, bus3.dp}), 32'({an3e, cur.s3[7*d3 +: 7], cur.p3[d3]}));
            chk("busy4", 32'(bus4.busy), 32'(busy_e));
            chk("busy3", 32'(bus3.busy), 32'(busy_e));
         end
      end
   end

   task automatic scramble();
      bus4.data_in  = DW'($urandom);
      bus3.data_in  = bus4.data_in;
      bus4.mode     = 1'($urandom);
      bus3.mode     = bus4.mode;
      bus4.blank_lz = 1'($urandom);
      bus3.blank_lz = bus4.blank_lz;
      bus4.dp_in    = 4'($urandom);
      bus3.dp_in    = bus4.dp_in[2:0];
   endtask

   task automatic do_load(input longint v, input bit dec, input bit blz, input logic [3:0] dpi);
      int L;
      @(negedge clk);
      L = cyc + 1;
      bus4.data_in  = DW'(v);
      bus3.data_in  = DW'(v);
      bus4.mode     = dec;
      bus3.mode     = dec;
      bus4.blank_lz = blz;
      bus3.blank_lz = blz;
      bus4.dp_in    = dpi;
      bus3.dp_in    = dpi[2:0];
      bus4.load     = 1'b1;
      bus3.load     = 1'b1;
      if (L >= next_free) begin
         if (dec) begin
            q.push_back(mk_img(v, 1'b1, blz, dpi, L + DW));
            bz_lo     = L;
            bz_hi     = L + DW - 1;
            next_free = L + DW + 1;
         end else begin
            q.push_back(mk_img(v, 1'b0, blz, dpi, L));
         end
      end
      @(negedge clk);
      bus4.load = 1'b0;
      bus3.load = 1'b0;
      scramble();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      q.delete();
      q.push_back(mk_img(0, 1'b0, 1'b0, 4'h0, 0));
      next_free = 0;
      bz_lo     = 1;
      bz_hi     = 0;
   endtask

   // Reset lands just after a rising edge so the next falling-edge sample
   // precedes any clock edge that a synchronous reset would need.
   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      idle(3);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      bus4.load = 1'b0;
      bus3.load = 1'b0;
      scramble();
      model_reset();
      idle(2);
      #1 rst_n = 1'b1;
      idle(6);

      do_load(10'h3FF, 1'b0, 1'b0, 4'h0);
      idle(4 * RD * 2);
      do_load(10'h005, 1'b0, 1'b1, 4'h0);
      idle(4 * RD * 2);
      do_load(1023, 1'b1, 1'b0, 4'h0);
      idle(DW + 4 * RD * 2);
      do_load(1000, 1'b1, 1'b1, 4'hF);
      idle(DW + 4 * RD * 2);
      do_load(999, 1'b1, 1'b0, 4'h0);
      idle(DW + 4 * RD * 2);
      do_load(512, 1'b1, 1'b0, 4'b0100);
      idle(2);
      do_load(7, 1'b1, 1'b0, 4'h0);
      do_load(3, 1'b0, 1'b0, 4'h0);
      idle(DW + 4 * RD * 2);
      do_load(0, 1'b1, 1'b1, 4'h1);
      idle(DW + 4 * RD * 2);

      do_load(700, 1'b1, 1'b0, 4'h0);
      repeat (4) @(posedge clk);
      do_reset();
      idle(4 * RD);
      do_load(1023, 1'b1, 1'b1, 4'h2);
      idle(DW + 4 * RD * 2);

      for (int n = 0; n < 40; n++) begin
         longint v;
         case ($urandom_range(0, 4))
            0:       v = 0;
            1:       v = 999 + longint'($urandom_range(0, 1));
            2:       v = longint'($urandom_range(0, 20));
            default: v = longint'($urandom_range(0, 1023));
         endcase
         do_load(v, 1'($urandom), 1'($urandom), 4'($urandom));
         idle($urandom_range(0, 25));
      end
      idle(DW + 4 * RD * 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
